// File: rtl/m8_capture_pkg.sv
// Shared types and helpers for the M8 event-capture block.
package m8_capture_pkg;

  localparam int unsigned EV_W = 3;
  localparam int unsigned TS_W = 8;

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [EV_W-1:0] mask;
  } ev_word_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/m8_event_capture_sync_fifo.sv
// Small FIFO with a registered head word; push and pop may coincide even when full.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d, level_after_pop;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             valid_q, valid_d;
  logic             full, do_push, do_pop;

  always_comb begin
    full            = level_q == LVL_W'(DEPTH);
    do_pop          = pop & valid_q;
    do_push         = push & (~full | do_pop);
    wr_ptr_d        = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d        = rd_ptr_q + PTR_W'(do_pop);
    level_after_pop = level_q - LVL_W'(do_pop);
    level_d         = level_after_pop + LVL_W'(do_push);
    valid_d         = level_d != '0;
    rdata_d         = rdata_q;
    // A word landing in an otherwise empty FIFO bypasses the array straight into the head.
    if (level_after_pop == '0) begin
      if (do_push) rdata_d = wdata;
    end else begin
      rdata_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
      valid_q  <= valid_d;
    end
  end

  // Storage array needs no reset: it is only read behind a nonzero level.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = rdata_q;
  assign valid = valid_q;
  assign level = level_q;

endmodule

// File: rtl/m8_event_capture.sv
// Synchronises the three M8 outputs, timestamps rising edges and buffers them as event words.
module m8_event_capture
  import m8_capture_pkg::EV_W, m8_capture_pkg::sat_inc8;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TS_W        = m8_capture_pkg::TS_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [EV_W-1:0]        ev_in,
  input  logic                   en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TS_W+EV_W-1:0]   out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             overflow_cnt
);

  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
  localparam int unsigned WORD_W = TS_W + EV_W;

  logic [SYNC_STAGES-1:0][EV_W-1:0] sync_q;
  logic [EV_W-1:0]                  prev_q, sync_last, mask;
  logic [TS_W-1:0]                  ts_q;
  logic [7:0]                       ovf_q, ovf_d;
  logic                             push, pop, full, drop;

  always_comb begin
    sync_last = sync_q[SYNC_STAGES-1];
    mask      = sync_last & ~prev_q;
    push      = en & (|mask);
    pop       = out_valid & out_ready;
    full      = level == LVL_W'(DEPTH);
    // A same-cycle pop frees a slot, so only a push into a full, non-draining FIFO is lost.
    drop      = push & full & ~pop;
    ovf_d     = drop ? sat_inc8(ovf_q) : ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
      ts_q   <= '0;
      ovf_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ev_in};
      prev_q <= sync_last;
      ts_q   <= ts_q + TS_W'(1);
      ovf_q  <= ovf_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({ts_q, mask}),
    .pop   (out_ready),
    .rdata (out_data),
    .valid (out_valid),
    .level (level)
  );

  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_m8_event_capture.sv
// Self-checking bench for m8_event_capture: vector table, corner sequences and random traffic vs a model.
module tb_m8_event_capture;
  import m8_capture_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned WW    = TS_W + EV_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    ev_in;
  logic          en;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_data;
  logic [2:0]    level;
  logic [7:0]    overflow_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of words, history of sampled inputs, cycle count since reset.
  logic [WW-1:0] mq[$];
  logic [2:0]    hist[$];
  int            ts_m;
  int            ovf_m;

  typedef struct {
    logic [2:0]    ev;
    logic          en;
    logic          rdy;
    logic          exp_valid;
    int            exp_level;
    logic          chk_data;
    logic [WW-1:0] exp_data;
  } vec_t;

  vec_t tbl[16];

  m8_event_capture #(.DEPTH(DEPTH), .TS_W(TS_W), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ev_in        (ev_in),
    .en           (en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .level        (level),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    hist.delete();
    for (int i = 0; i <= SYNC; i++) hist.push_back(3'b000);
    ts_m  = 0;
    ovf_m = 0;
  endtask

  // One clock edge of the specified behaviour: an input sampled SYNC edges ago that was low one sample earlier is an edge.
  task automatic model_edge();
    logic [2:0] m;
    ev_word_t   w;
    m = hist[SYNC-1] & ~hist[SYNC];
    if (mq.size() != 0 && out_ready) void'(mq.pop_front());
    if (en && m != 3'b000) begin
      if (mq.size() < DEPTH) begin
        w.ts   = TS_W'(ts_m);
        w.mask = m;
        mq.push_back(w);
      end else if (ovf_m < 255) begin
        ovf_m++;
      end
    end
    ts_m = (ts_m + 1) % 256;
    hist.push_front(ev_in);
    void'(hist.pop_back());
  endtask

  task automatic compare_model();
    chk("model_valid", int'(out_valid), int'(mq.size() != 0));
    chk("model_level", int'(level), mq.size());
    chk("model_ovf", int'(overflow_cnt), ovf_m);
    if (mq.size() != 0) chk("model_data", int'(out_data), int'(mq[0]));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_model();
  endtask

  task automatic pulse(input logic [2:0] bits);
    ev_in = bits;
    repeat (3) step();
    ev_in = 3'b000;
    repeat (3) step();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int g = 0; g < 20 && mq.size() != 0; g++) step();
    step();
    out_ready = 1'b0;
    chk("drain_level", int'(level), 0);
  endtask

  initial begin
    tbl[0]  = '{3'b001, 1'b1, 1'b0, 1'b0, 0, 1'b0, 11'h000};
    tbl[1]  = '{3'b001, 1'b1, 1'b0, 1'b0, 0, 1'b0, 11'h000};
    tbl[2]  = '{3'b001, 1'b1, 1'b0, 1'b1, 1, 1'b1, 11'h081};
    tbl[3]  = '{3'b000, 1'b1, 1'b1, 1'b0, 0, 1'b0, 11'h000};
    tbl[4]  = '{3'b000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 11'h000};
    tbl[5]  = '{3'b000, 1'b1, 1'b0, 1'b0, 0, 1'b0, 11'h000};
    tbl[6]  = '{3'b101, 1'b1, 1'b0, 1'b0, 0, 1'b0, 11'h000};
    tbl[7]  = '{3'b101, 1'b1, 1'b0, 1'b0, 0, 1'b0, 11'h000};
    tbl[8]  = '{3'b101, 1'b1, 1'b0, 1'b1, 1, 1'b1, 11'h0B5};
    tbl[9]  = '{3'b101, 1'b1, 1'b0, 1'b1, 1, 1'b1, 11'h0B5};
    tbl[10] = '{3'b000, 1'b1, 1'b0, 1'b1, 1, 1'b1, 11'h0B5};
    tbl[11] = '{3'b010, 1'b0, 1'b0, 1'b1, 1, 1'b1, 11'h0B5};
    tbl[12] = '{3'b010, 1'b0, 1'b0, 1'b1, 1, 1'b1, 11'h0B5};
    tbl[13] = '{3'b010, 1'b0, 1'b0, 1'b1, 1, 1'b1, 11'h0B5};
    tbl[14] = '{3'b010, 1'b1, 1'b0, 1'b1, 1, 1'b1, 11'h0B5};
    tbl[15] = '{3'b010, 1'b1, 1'b1, 1'b0, 0, 1'b0, 11'h000};

    rst_n = 1'b0;
    ev_in = 3'b000;
    en = 1'b1;
    out_ready = 1'b0;
    model_reset();
    #2;
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_level", int'(level), 0);
    chk("reset_data", int'(out_data), 0);
    chk("reset_ovf", int'(overflow_cnt), 0);
    repeat (2) step();
    rst_n = 1'b1;

    // Fourteen idle edges so the first table edge sees ts = 14 and the first write lands on ts = 0x10.
    repeat (14) step();
    for (int i = 0; i < 16; i++) begin
      ev_in = tbl[i].ev;
      en = tbl[i].en;
      out_ready = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].exp_level);
      if (tbl[i].chk_data) chk($sformatf("tbl%0d_data", i), int'(out_data), int'(tbl[i].exp_data));
    end
    en = 1'b1;
    out_ready = 1'b0;
    ev_in = 3'b000;
    repeat (3) step();

    // Overflow: six events into a 4-deep FIFO with nobody draining.
    pulse(3'b001); pulse(3'b010); pulse(3'b100);
    pulse(3'b011); pulse(3'b110); pulse(3'b101);
    chk("ovf_level", int'(level), 4);
    chk("ovf_count", int'(overflow_cnt), 2);
    chk("ovf_head_mask", int'(out_data[2:0]), 1);

    // Full FIFO: push and pop on the same edge.
    ev_in = 3'b001;
    repeat (2) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    ev_in = 3'b000;
    chk("fullpp_level", int'(level), 4);
    chk("fullpp_ovf", int'(overflow_cnt), 2);
    chk("fullpp_head_mask", int'(out_data[2:0]), 2);
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      ev_in = 3'($urandom_range(0, 7));
      en = ($urandom_range(0, 7) != 0);
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    en = 1'b1;
    ev_in = 3'b000;
    repeat (3) step();
    drain();

    // Asynchronous reset mid-stream with three words queued and an edge in flight.
    pulse(3'b001); pulse(3'b010); pulse(3'b100);
    chk("rst_pre_level", int'(level), 3);
    ev_in = 3'b010;
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", int'(out_valid), 0);
    chk("rst_async_level", int'(level), 0);
    chk("rst_async_ovf", int'(overflow_cnt), 0);
    chk("rst_async_data", int'(out_data), 0);
    model_reset();
    ev_in = 3'b000;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (8) step();
    chk("rst_post_valid", int'(out_valid), 0);
    chk("rst_post_level", int'(level), 0);

    // Timestamp wrap: one event at ts 0xFA, the next at ts 0x00.
    for (int g = 0; g < 300 && ts_m != 8'hF8; g++) step();
    ev_in = 3'b001;
    repeat (3) step();
    for (int g = 0; g < 300 && ts_m != 8'hFE; g++) step();
    ev_in = 3'b011;
    repeat (3) step();
    chk("wrap_level", int'(level), 2);
    chk("wrap_first", int'(out_data), 11'h7D1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("wrap_second", int'(out_data), 11'h002);
    chk("wrap_level_after", int'(level), 1);
    drain();

    // Saturation: about 300 dropped words with the FIFO full.
    for (int i = 0; i < 620; i++) begin
      ev_in = (i % 2 == 0) ? 3'b111 : 3'b000;
      step();
    end
    chk("sat_ovf", int'(overflow_cnt), 255);
    chk("sat_level", int'(level), 4);
    for (int i = 0; i < 20; i++) begin
      ev_in = (i % 2 == 0) ? 3'b111 : 3'b000;
      step();
    end
    chk("sat_hold", int'(overflow_cnt), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
